fp32_p160: RTL and testbench

Pipelined converter from IEEE-754 binary32 to posit⟨16,0⟩; it is the inverse of the existing posit⟨16,0⟩→fp32 path. It sits at the boundary between fp32-producing logic and posit16 datapaths. The block has a 3-stage pipeline with valid/ready handshakes on both sides, accepts one conversion per cycle, and rounds to nearest, ties to even, in the posit domain.

---
 rtl/posit16_pkg.sv | 39 +++
 rtl/reg16_enc.sv | 48 ++++
 rtl/fp32_p160.sv | 160 ++++++++++++++++
 tb/tb_fp32_p160.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/posit16_pkg.sv
// posit16_pkg: shared constants and types for the fp32 <-> posit<16,0> paths.
//   fp32_t     : binary32 split into sign / biased exponent / mantissa
//   p16_cls_e  : how a binary32 operand maps into the posit16 range
//   classify() : pure function producing p16_cls_e from an fp32_t
package posit16_pkg;

  localparam int          P16_N      = 16;
  localparam int          P16_ES     = 0;
  localparam logic [15:0] P16_NAR    = 16'h8000;
  localparam logic [15:0] P16_MAXPOS = 16'h7FFF;
  localparam logic [15:0] P16_MINPOS = 16'h0001;
  localparam int          FP32_BIAS  = 127;
  localparam int          P16_KMAX   = 14;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [2:0] {
    ZERO,     // exponent field 0: zero or denormal, flushed
    NAR,      // exponent field all ones: Inf or NaN
    NORMAL,   // scale fits the posit16 regime range
    SAT_HI,   // scale above maxpos
    SAT_LO    // scale below minpos
  } p16_cls_e;

  function automatic p16_cls_e classify(input fp32_t f);
    logic signed [8:0] k;
    k = $signed({1'b0, f.exp}) - 9'(FP32_BIAS);
    if (f.exp == 8'd0)               return ZERO;
    else if (&f.exp)                 return NAR;
    else if (k > 9'(P16_KMAX))       return SAT_HI;
    else if (k < -9'(P16_KMAX))      return SAT_LO;
    else                             return NORMAL;
  endfunction

endpackage

// File: rtl/reg16_enc.sv
// reg16_enc: combinational regime/fraction packer for posit<16,0>.
// Inverse of the reg16 decoder.
//   k      in  7  signed scale, valid range -14..14
//   m      in  23 fp32 mantissa (hidden bit implied)
//   body   out 15 unrounded magnitude: regime bits then leading fraction bits
//   guard  out 1  first discarded mantissa bit
//   sticky out 1  OR of all mantissa bits below guard
module reg16_enc
  import posit16_pkg::*;
(
  input  logic [6:0]  k,
  input  logic [22:0] m,
  output logic [14:0] body,
  output logic        guard,
  output logic        sticky
);

  logic signed [47:0] seed;
  logic signed [47:0] shifted;
  logic [5:0]         sh;

  // Seed is {first regime bit, terminator, mantissa, pad}. An arithmetic
  // right shift replicates the first regime bit, giving k+1 ones then a
  // zero (k >= 0) or -k zeros then a one (k < 0, shift by -k-1 == ~k).
  always_comb begin
    if (!k[6]) begin
      seed = {2'b10, m, 23'd0};
      sh   = k[5:0];
    end else begin
      seed = {2'b01, m, 23'd0};
      sh   = ~k[5:0];
    end
    shifted = seed >>> sh;

    // At k == kmax the regime fills all 15 bits and the terminator is
    // dropped, so guard must come straight from the mantissa MSB.
    if (k == 7'(P16_KMAX)) begin
      body   = P16_MAXPOS[14:0];
      guard  = m[22];
      sticky = |m[21:0];
    end else begin
      body   = shifted[47:33];
      guard  = shifted[32];
      sticky = |shifted[31:0];
    end
  end

endmodule

// File: rtl/fp32_p160.sv
// fp32_p160: 3-stage pipelined IEEE-754 binary32 -> posit<16,0> converter,
// round to nearest / ties to even in the posit domain.
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    input handshake, in_fp32 operand
//   out_valid/out_ready  output handshake
//   out_p16              two's-complement posit16 result
//   out_nar              input was Inf/NaN (result 0x8000)
//   out_sat              result clamped to +-maxpos / +-minpos
module fp32_p160
  import posit16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_fp32,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p16,
  output logic        out_nar,
  output logic        out_sat
);

  typedef struct packed {
    p16_cls_e    cls;
    logic        sign;
    logic [6:0]  k;
    logic [22:0] mant;
  } s1_t;

  typedef struct packed {
    p16_cls_e    cls;
    logic        sign;
    logic [14:0] body;
    logic        guard;
    logic        sticky;
  } s2_t;

  typedef struct packed {
    logic [P16_N-1:0] p16;
    logic             nar;
    logic             sat;
  } s3_t;

  logic [3:1] vld_pipe;
  logic [3:1] en;
  s1_t        s1, s1_d;
  s2_t        s2, s2_d;
  s3_t        s3, s3_d;
  fp32_t      f;

  logic [14:0] enc_body;
  logic        enc_guard;
  logic        enc_sticky;
  logic [15:0] rnd;
  logic [14:0] mag;

  // Enables ripple back from the consumer so bubbles collapse.
  always_comb begin
    en[3] = !vld_pipe[3] | out_ready;
    en[2] = !vld_pipe[2] | en[3];
    en[1] = !vld_pipe[1] | en[2];
  end

  assign in_ready = en[1];

  // S1: classify and split fields. Only k mod 128 is kept; it is exact
  // for the NORMAL range, the only class that consumes it.
  always_comb begin
    f         = fp32_t'(in_fp32);
    s1_d.cls  = classify(f);
    s1_d.sign = f.sign;
    s1_d.k    = f.exp[6:0] - 7'd127;
    s1_d.mant = f.mant;
  end

  // S2: regime/fraction packing.
  reg16_enc u_enc (
    .k      (s1.k),
    .m      (s1.mant),
    .body   (enc_body),
    .guard  (enc_guard),
    .sticky (enc_sticky)
  );

  always_comb begin
    s2_d.cls    = s1.cls;
    s2_d.sign   = s1.sign;
    s2_d.body   = enc_body;
    s2_d.guard  = enc_guard;
    s2_d.sticky = enc_sticky;
  end

  // S3: RNE round, clamp, apply sign.
  always_comb begin
    s3_d = '0;
    mag  = '0;
    rnd  = {1'b0, s2.body} + 16'(s2.guard & (s2.body[0] | s2.sticky));
    case (s2.cls)
      ZERO: mag = '0;
      NAR: begin
        s3_d.nar = 1'b1;
      end
      SAT_HI: begin
        mag      = P16_MAXPOS[14:0];
        s3_d.sat = 1'b1;
      end
      SAT_LO: begin
        mag      = P16_MINPOS[14:0];
        s3_d.sat = 1'b1;
      end
      NORMAL: begin
        if (rnd[15]) begin
          mag      = P16_MAXPOS[14:0];
          s3_d.sat = 1'b1;
        end else if (rnd[14:0] == 15'd0) begin
          mag = P16_MINPOS[14:0];
        end else begin
          mag = rnd[14:0];
        end
      end
      default: mag = '0;
    endcase

    if (s2.cls == NAR)
      s3_d.p16 = P16_NAR;
    else if (s2.sign)
      s3_d.p16 = ~{1'b0, mag} + 16'd1;
    else
      s3_d.p16 = {1'b0, mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
    end else begin
      if (en[1]) begin
        vld_pipe[1] <= in_valid;
        s1          <= s1_d;
      end
      if (en[2]) begin
        vld_pipe[2] <= vld_pipe[1];
        s2          <= s2_d;
      end
      if (en[3]) begin
        vld_pipe[3] <= vld_pipe[2];
        s3          <= s3_d;
      end
    end
  end

  assign out_valid = vld_pipe[3];
  assign out_p16   = s3.p16;
  assign out_nar   = s3.nar;
  assign out_sat   = s3.sat;

endmodule

// File: tb/tb_fp32_p160.sv
// tb_fp32_p160: directed + randomized bench for fp32_p160 with a
// bit-string reference model and an in-flight scoreboard.
module tb_fp32_p160;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_fp32;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_p16;
  logic        out_nar;
  logic        out_sat;

  fp32_p160 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fp32   (in_fp32),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p16   (out_p16),
    .out_nar   (out_nar),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  bit          bp_mode = 1'b0;
  logic [17:0] exp_q[$];
  int          acc_q[$];
  bit          prev_hold = 1'b0;
  logic [17:0] prev_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: write the posit as a literal bit string (regime bits then the
  // whole mantissa), keep the top 15 bits, round with guard/sticky.
  // Returns {nar, sat, p16}.
  function automatic logic [17:0] ref_conv(input logic [31:0] x);
    int              e, k, r, mag;
    longint unsigned rg, full, body;
    bit              g, st, sat;
    logic [15:0]     p;
    e   = int'(x[30:23]);
    k   = e - 127;
    sat = 1'b0;
    if (e == 0) mag = 0;
    else if (e == 255) return {1'b1, 1'b0, 16'h8000};
    else if (k > 14) begin mag = 32'h7FFF; sat = 1'b1; end
    else if (k < -14) begin mag = 1; sat = 1'b1; end
    else begin
      if (k >= 0) begin
        rg = ((64'd1 << (k + 1)) - 64'd1) << 1;
        r  = k + 2;
        if (r > 15) begin rg = rg >> 1; r = 15; end
      end else begin
        rg = 64'd1;
        r  = 1 - k;
      end
      full = (rg << 23) | longint'(x[22:0]);
      body = full >> (r + 8);
      g    = full[r + 7];
      st   = (full & ((64'd1 << (r + 7)) - 64'd1)) != 0;
      mag  = int'(body) + int'(g & (body[0] | st));
      if (mag > 32'h7FFF) begin mag = 32'h7FFF; sat = 1'b1; end
      if (mag == 0) mag = 1;
    end
    p = mag[15:0];
    if (x[31]) p = -p;
    return {1'b0, sat, p};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] x;
    int          n;
    x = $urandom;
    if ($urandom_range(0, 9) < 7) x[30:23] = 8'($urandom_range(108, 146));
    if ($urandom_range(0, 3) == 0) begin
      n = $urandom_range(1, 22);
      x[22:0] = (x[22:0] & ~23'((1 << n) - 1)) | 23'(1 << (n - 1));
    end
    return x;
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? 1'($urandom) : 1'b1;
  end

  // Scoreboard: exp_q holds exactly the conversions occupying the pipe.
  always @(negedge clk) begin
    logic [17:0] e;
    int          a;
    cyc++;
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 3 && !out_ready)));
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({out_nar, out_sat, out_p16}), 32'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("stale", 32'(out_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("result", 32'({out_nar, out_sat, out_p16}), 32'(e));
          if (out_nar && out_sat) chk("flags_excl", 32'(out_sat), 32'd0);
          if (lat_chk) chk("latency", 32'(cyc - a), 32'd3);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_conv(in_fp32));
        acc_q.push_back(cyc);
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_nar, out_sat, out_p16};
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic send(input logic [31:0] x);
    int t;
    in_valid = 1'b1;
    in_fp32  = x;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 200);
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_fp32  = $urandom;
  endtask

  task automatic dir(input logic [31:0] x, input logic [17:0] e);
    int t;
    send(x);
    t = 0;
    while (!out_valid && t < 10) begin @(negedge clk); t++; end
    chk("directed", 32'({out_valid, out_nar, out_sat, out_p16}), 32'({1'b1, e}));
    @(posedge clk); #1;
  endtask

  localparam logic [31:0] DIN [13] = '{
    32'h3F800000, 32'hBF800000, 32'h3FC00000, 32'h40000000, 32'h3F000000,
    32'h3F800200, 32'h3F800600, 32'h3F800201,
    32'h7F800000, 32'h00000005, 32'h501502F9, 32'h00800000, 32'hD01502F9};
  localparam logic [17:0] DEXP [13] = '{
    {2'b00, 16'h4000}, {2'b00, 16'hC000}, {2'b00, 16'h5000}, {2'b00, 16'h6000},
    {2'b00, 16'h2000}, {2'b00, 16'h4000}, {2'b00, 16'h4002}, {2'b00, 16'h4001},
    {2'b10, 16'h8000}, {2'b00, 16'h0000}, {2'b01, 16'h7FFF}, {2'b01, 16'h0001},
    {2'b01, 16'h8001}};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_fp32  = '0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'({out_nar, out_sat, out_p16}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed values with latency tracking.
    lat_chk = 1'b1;
    for (int i = 0; i < 13; i++) dir(DIN[i], DEXP[i]);
    lat_chk = 1'b0;

    // Random stream under random backpressure.
    bp_mode = 1'b1;
    for (int i = 0; i < 240; i++) begin
      send(rnd_fp());
      if (i >= 8) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    bp_mode = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    chk("drain", 32'(exp_q.size()), 32'd0);

    // Reset with three conversions in flight (NaR at the head).
    repeat (2) @(posedge clk); #1;
    send(32'h7F800000);
    send(32'h3F800000);
    send(32'h40000000);
    chk("pre_rst_valid", 32'({out_valid, out_nar}), 32'b11);
    #1 rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out", 32'({out_nar, out_sat, out_p16}), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    chk("rst_hold_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    lat_chk = 1'b1;
    dir(32'hC0000000, {2'b00, 16'hA000});
    repeat (4) @(posedge clk);
    chk("post_rst_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
